// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait hold and sticky timeout error.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic idex_hold;
        logic exmem_hold;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } ctrl_t;

    state_t            state_q, state_d;
    logic              pend_br_q, pend_br_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic              load_use;
    ctrl_t             ctrl;

    // x0 is hard-wired to zero, so a load targeting it can never create a hazard.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pend_br_d  = pend_br_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        ctrl       = '0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    ctrl.pc_hold     = 1'b1;
                    ctrl.ifid_hold   = 1'b1;
                    ctrl.idex_hold   = 1'b1;
                    ctrl.exmem_hold  = 1'b1;
                    ctrl.memwb_flush = 1'b1;
                    pend_br_d        = branch_taken;
                    wait_cnt_d       = WCNT_W'(1);
                    state_d          = ST_WAIT;
                end else if (branch_taken) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_hold  = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end
            end

            ST_WAIT: begin
                if (mem_busy) begin
                    ctrl.pc_hold     = 1'b1;
                    ctrl.ifid_hold   = 1'b1;
                    ctrl.idex_hold   = 1'b1;
                    ctrl.exmem_hold  = 1'b1;
                    ctrl.memwb_flush = 1'b1;
                    pend_br_d        = pend_br_q | branch_taken;
                    if (wait_cnt_q == WCNT_MAX) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end else begin
                    // Release cycle: replay any redirect seen while frozen; load-use is not checked here.
                    ctrl.ifid_flush = pend_br_q | branch_taken;
                    ctrl.idex_flush = pend_br_q | branch_taken;
                    pend_br_d       = 1'b0;
                    wait_cnt_d      = '0;
                    state_d         = ST_RUN;
                end
            end

            ST_ERR: begin
                ctrl.pc_hold     = 1'b1;
                ctrl.exmem_hold  = 1'b1;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_flush  = 1'b1;
                ctrl.memwb_flush = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Quiet pipeline controls while reset is held, whatever the inputs are doing.
        if (!reset) begin
            ctrl = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            pend_br_q  <= 1'b0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_br_q  <= pend_br_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign pc_hold     = ctrl.pc_hold;
    assign ifid_hold   = ctrl.ifid_hold;
    assign idex_hold   = ctrl.idex_hold;
    assign exmem_hold  = ctrl.exmem_hold;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign mem_err     = mem_err_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctrl.pc_hold && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ctrl.idex_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max consecutive mem_busy cycles before error (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, width of performance counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  ID-stage source register indices.
REQ-006 SHALL have ports ex_rd  input  5, ex_memread  input  1  EX-stage destination and load flag.
REQ-007 SHALL have port branch_taken  input  1  EX-stage redirect (branch/jump taken).
REQ-008 SHALL have port mem_busy  input  1  data memory not ready this cycle.
REQ-009 SHALL have outputs pc_hold, ifid_hold, idex_hold, exmem_hold  output  1 each  keep the stage register's current value.
REQ-010 SHALL have outputs ifid_flush, idex_flush, memwb_flush  output  1 each  load zero into the stage register.
REQ-011 SHALL have output mem_err  output  1  sticky memory-timeout error.
REQ-012 SHALL have outputs stall_cnt, flush_cnt  output  CNT_W each  performance counters (see Configuration).

Function
REQ-013 SHALL implement FSM states RUN, WAIT, ERR; hold/flush outputs are combinational decode of state and inputs.
REQ-014 RUN, mem_busy=1: SHALL assert pc_hold, ifid_hold, idex_hold, exmem_hold, memwb_flush in the same cycle; capture pend_br<=branch_taken; load wait count=1; next state WAIT.
REQ-015 RUN, mem_busy=0, branch_taken=1: SHALL assert ifid_flush and idex_flush only; branch takes priority over load-use.
REQ-016 RUN, mem_busy=0, branch_taken=0, load-use (ex_memread=1, ex_rd!=0, ex_rd equals id_rs1 or id_rs2): SHALL assert pc_hold, ifid_hold, idex_flush for exactly that cycle.
REQ-017 ex_rd=0 SHALL never produce a load-use stall.
REQ-018 WAIT, mem_busy=1: SHALL assert the REQ-014 hold set; pend_br<=pend_br|branch_taken; count increments.
REQ-019 WAIT, mem_busy=1 with count=MEM_TIMEOUT: SHALL go to ERR next cycle and set mem_err.
REQ-020 WAIT, mem_busy=0 (release cycle): no holds; ifid_flush=idex_flush=pend_br|branch_taken; pend_br cleared; next state RUN; load-use SHALL NOT be evaluated in the release cycle.
REQ-021 ERR: SHALL assert pc_hold and ifid_flush, idex_flush, memwb_flush; exmem_hold=1; remain in ERR until reset, ignoring all inputs.
REQ-022 Hold and flush SHALL never both be asserted for the same stage register.
REQ-023 Wait count SHALL be $clog2(MEM_TIMEOUT+1) bits and never wrap.

Reset
REQ-024 reset=0 SHALL asynchronously force state RUN, pend_br=0, count=0, mem_err=0, stall_cnt=0, flush_cnt=0.
REQ-025 During reset all hold/flush outputs SHALL be 0; reset mid-WAIT or in ERR SHALL discard pend_br and resume RUN on the first edge after release.

Configuration
REQ-026 Macro PIPE_HAZARD_PERF_CNT_EN defined: stall_cnt SHALL increment each cycle pc_hold=1; flush_cnt SHALL increment each cycle idex_flush=1; both saturate at all-ones.
REQ-027 Macro undefined: stall_cnt and flush_cnt SHALL be tied to 0 with no counter registers; all other behaviour identical.

Verification
REQ-028 Load-use: ex_memread=1, ex_rd=5, id_rs2=5, mem_busy=0, branch_taken=0 -> one cycle pc_hold=ifid_hold=idex_flush=1; ex_rd=0 same stimulus -> all 0.
REQ-029 Branch plus load-use same cycle -> ifid_flush=idex_flush=1, pc_hold=0.
REQ-030 mem_busy high 3 cycles, branch_taken pulsed in second -> holds for 3 cycles, release cycle ifid_flush=idex_flush=1, state RUN.
REQ-031 MEM_TIMEOUT=4, mem_busy held high -> mem_err=1 after 4 WAIT cycles, stays 1 after mem_busy drops; reset=0 clears it asynchronously.
REQ-032 PIPE_HAZARD_PERF_CNT_EN on, CNT_W=4, 20 stall cycles -> stall_cnt=15; macro off -> stall_cnt=0.
